ser_frame_scheduler: RTL and testbench
======================================

# ser_frame_scheduler

Round-robin scheduler that shares one serial output line among four requesters and sequences each granted request into a serial frame. A frame is start bit, 2-bit port, 4-bit length, then data. The block sits in front of the serial demux system. It drives that system's `ser_in` and advances one bit per `clk_en` pulse from the one-pulser. The port field is the granted requester's index, so requester i's data lands on demux output p<i>.

## Interface
- `LEN_W`, 4: width of the length field; the frame carries 0..2^LEN_W-1 data bits.
- `DATA_W`, 15: data bits per requester; must equal 2^LEN_W-1.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `clk_en` input 1: bit-period strobe, one `clk` cycle wide; the FSM advances only on edges where it is 1.
- `req` input 4: `req[i]` high = requester i has a frame pending.
- `len_i` input 4*LEN_W: packed lengths, requester i at `[i*LEN_W +: LEN_W]`.
- `data_i` input 4*DATA_W: packed payloads, requester i at `[i*DATA_W +: DATA_W]`.
- `gnt` output 4: one-hot, single-`clk` pulse marking the cycle in which requester i's frame was captured.
- `ser_out` output 1: serial line, registered; idles high.
- `busy` output 1: high from capture until the frame's GAP bit ends.
- `frame_done` output 1: single-`clk` pulse when the GAP bit ends.
- `cur_port` output 2: index of the requester currently being sent; holds its last value when idle.

## Operation
- States: IDLE, START, ADDR, LEN, DATA, PAR (macro only), GAP.
- **IDLE, capture:** on an edge with `clk_en`=1 and `req`!=0:
  - pick the winner round-robin, searching upward from (last granted + 1) mod 4;
  - latch its len and data, set `cur_port`, pulse `gnt[winner]`;
  - drive `ser_out`=0 and enter START.
- **IDLE, no capture:** with `clk_en`=0 or `req`=0, stay in IDLE with `ser_out`=1.
- **Bit advance:** each later `clk_en` edge moves to the next bit:
  - START → ADDR, sending port[1] then port[0];
  - ADDR → LEN, sending len MSB first, 4 bits;
  - LEN → DATA, sending data[0], data[1], … data[len-1], LSB first;
  - DATA → GAP, which sends `ser_out`=1 for one bit period;
  - GAP → IDLE, pulsing `frame_done` and dropping `busy`.
- **Zero length:** len=0 skips DATA; LEN goes straight to GAP (or PAR).
- **Bit counter:** a 4-bit counter indexes ADDR/LEN/DATA bits and resets on each state entry.
- **Requester contract:** requester i holds `req[i]`, `len_i` and `data_i` stable until `gnt[i]`, then drops or re-arms `req[i]`.
  - Inputs are latched at capture; later changes do not affect the frame in flight.
- **Dropped request:** a requester that drops `req` before it is granted is never granted.
- **`req` while busy:** ignored until the scheduler returns to IDLE.

## Timing
- **Reset values:** `ser_out`=1, `gnt`=0, `busy`=0, `frame_done`=0, `cur_port`=0, state IDLE.
  - The round-robin pointer resets to 3, so requester 0 has first priority.
- **Reset mid-frame:** the frame is aborted; `ser_out`=1 on the edge after `rst` is sampled low; no `gnt` or `frame_done` pulse.
- **Grant latency:** `gnt`, `busy`=1 and `ser_out`=0 all appear on the same capture edge (registered outputs).
- **Bit period:** one bit per `clk_en` edge; `ser_out` is stable between `clk_en` edges.
- **Frame length:** 1 + 2 + 4 + len + 1 bit periods, plus 1 with parity.
- **Back-to-back frames:** at least one IDLE `clk_en` after GAP before the next start bit, so the line shows ≥2 high bits between frames.
- **Held `clk_en`:** held high for consecutive `clk` cycles, it advances one bit per cycle with no other change in behaviour.

## Configuration
- `SER_PARITY_EN` defined:
  - adds state PAR between DATA (or LEN when len=0) and GAP;
  - PAR sends one even-parity bit over port, len and the len data bits, so the total count of ones is even.
- `SER_PARITY_EN` undefined: PAR does not exist and the frame is as described above.

## Test plan
- **Single frame:** `req`=0010, len1=3, data1=...101 → `gnt`=0010 pulse; `ser_out` per bit = 0,0,1,0,0,1,1,1,0,1,1; `cur_port`=1; `frame_done` pulse at GAP end.
- **Round robin:** `req`=1111 held, each requester re-arming after `gnt` → grant order 0,1,2,3,0; `busy` low for at least one `clk_en` between frames.
- **Zero length:** `req`=1000, len3=0 → `ser_out` = 0,1,1,0,0,0,0,1; `frame_done` after 8 bit periods.
- **Strobe gating:** `clk_en` held low for 10 cycles mid-DATA → `ser_out` and state hold; the sequence resumes unchanged when `clk_en` returns.
- **Reset mid-frame:** `rst`=0 during DATA → `ser_out`=1, `busy`=0 on the next edge, no `frame_done`; the next request goes to requester 0 first.
- **Parity:** with `SER_PARITY_EN` and the single-frame stimulus → parity bit 1 inserted before GAP; frame length 12 bit periods.

Source files
------------

// File: rtl/ser_frame_if.sv
// ser_frame_if: requester-side bundle for ser_frame_scheduler.
// Handshake: requester i raises req[i] with len/data stable; the scheduler
// captures them on a clk_en edge and pulses gnt[i] for one clk. After gnt the
// requester may drop req[i] or keep it high (re-arm) with a new frame.
interface ser_frame_if #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 15
);
  logic [3:0]          req;
  logic [4*LEN_W-1:0]  len_i;
  logic [4*DATA_W-1:0] data_i;
  logic [3:0]          gnt;
  logic                ser_out;
  logic                busy;
  logic                frame_done;
  logic [1:0]          cur_port;
  logic [2:0]          state_dbg;

  modport master (
    output req, len_i, data_i,
    input  gnt, ser_out, busy, frame_done, cur_port, state_dbg
  );

  modport slave (
    input  req, len_i, data_i,
    output gnt, ser_out, busy, frame_done, cur_port, state_dbg
  );
endinterface

// File: rtl/ser_frame_scheduler.sv
// ser_frame_scheduler: round-robin arbiter over four requesters that emits
// each granted request as a serial frame: start, port[1:0], len MSB first,
// data LSB first, [parity], gap. One bit per clk_en edge.
// Optional macro SER_PARITY_EN inserts an even-parity bit before the gap.
module ser_frame_scheduler #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  ser_frame_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          port_q, port_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    lsh_q, lsh_d;
  logic [DATA_W-1:0]   dsh_q, dsh_d;
  logic                ser_q, ser_d;
  logic [3:0]          gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SER_PARITY_EN
  logic                par_q, par_d;
  logic [DATA_W-1:0]   win_mask;
`endif

  logic [1:0]          win;
  logic [1:0]          idx;
  logic                found;
  logic [LEN_W-1:0]    win_len;
  logic [DATA_W-1:0]   win_data;
  state_t              tail_state;
  logic                tail_bit;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_len  = bus.len_i[int'(win)*LEN_W +: LEN_W];
    win_data = bus.data_i[int'(win)*DATA_W +: DATA_W];
  end

  // State after the payload: parity bit when enabled, otherwise the gap.
  always_comb begin
`ifdef SER_PARITY_EN
    tail_state = S_PAR;
    tail_bit   = par_q;
    win_mask   = (DATA_W'(1) << win_len) - DATA_W'(1);
    par_d      = par_q;
`else
    tail_state = S_GAP;
    tail_bit   = 1'b1;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    len_d   = len_q;
    lsh_d   = lsh_q;
    dsh_d   = dsh_q;
    ser_d   = ser_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          ser_d = 1'b1;
          if (|bus.req) begin
            gnt_d[win] = 1'b1;
            ptr_d      = win;
            port_d     = win;
            len_d      = win_len;
            lsh_d      = win_len;
            dsh_d      = win_data;
            busy_d     = 1'b1;
            ser_d      = 1'b0;
            state_d    = S_START;
`ifdef SER_PARITY_EN
            par_d      = ^{win, win_len, win_data & win_mask};
`endif
          end
        end
        S_START: begin
          ser_d   = port_q[1];
          cnt_d   = '0;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          if (cnt_q == 4'd0) begin
            ser_d = port_q[0];
            cnt_d = 4'd1;
          end else begin
            ser_d   = lsh_q[LEN_W-1];
            lsh_d   = lsh_q << 1;
            cnt_d   = '0;
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (cnt_q != 4'(LEN_W-1)) begin
            ser_d = lsh_q[LEN_W-1];
            lsh_d = lsh_q << 1;
            cnt_d = cnt_q + 4'd1;
          end else if (len_q == '0) begin
            ser_d   = tail_bit;
            cnt_d   = '0;
            state_d = tail_state;
          end else begin
            ser_d   = dsh_q[0];
            dsh_d   = dsh_q >> 1;
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if ((5'(cnt_q) + 5'd1) < 5'(len_q)) begin
            ser_d = dsh_q[0];
            dsh_d = dsh_q >> 1;
            cnt_d = cnt_q + 4'd1;
          end else begin
            ser_d   = tail_bit;
            cnt_d   = '0;
            state_d = tail_state;
          end
        end
`ifdef SER_PARITY_EN
        S_PAR: begin
          ser_d   = 1'b1;
          state_d = S_GAP;
        end
`endif
        S_GAP: begin
          ser_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          ser_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Register all state and outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      port_q  <= '0;
      len_q   <= '0;
      lsh_q   <= '0;
      dsh_q   <= '0;
      ser_q   <= 1'b1;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      len_q   <= len_d;
      lsh_q   <= lsh_d;
      dsh_q   <= dsh_d;
      ser_q   <= ser_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.ser_out    = ser_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.cur_port   = port_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_ser_frame_scheduler.sv
// Directed testbench for ser_frame_scheduler (default or SER_PARITY_EN build).
module tb_ser_frame_scheduler;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 15;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic clk_en = 1'b0;

  ser_frame_if #(.LEN_W(LEN_W), .DATA_W(DATA_W)) bus();

  ser_frame_scheduler #(.LEN_W(LEN_W), .DATA_W(DATA_W)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  req_v;
  logic [3:0]  len_v  [4];
  logic [14:0] data_v [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req = req_v;
    for (int i = 0; i < 4; i++) begin
      bus.len_i[i*LEN_W +: LEN_W]    = len_v[i];
      bus.data_i[i*DATA_W +: DATA_W] = data_v[i];
    end
  endtask

  // One clk_en pulse; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
  endtask

  // Reference frame: start, port MSB first, len MSB first, data LSB first,
  // optional even parity, gap.
  function automatic void build_frame(input logic [1:0] p, input logic [3:0] l,
                                      input logic [14:0] d,
                                      output logic [31:0] bits, output int n);
`ifdef SER_PARITY_EN
    logic par;
`endif
    bits = '0;
    n    = 0;
    bits[n] = 1'b0; n++;
    bits[n] = p[1]; n++;
    bits[n] = p[0]; n++;
    for (int i = 3; i >= 0; i--) begin
      bits[n] = l[i]; n++;
    end
    for (int i = 0; i < int'(l); i++) begin
      bits[n] = d[i]; n++;
    end
`ifdef SER_PARITY_EN
    par = p[0] ^ p[1];
    for (int i = 0; i < 4; i++) par = par ^ l[i];
    for (int i = 0; i < int'(l); i++) par = par ^ d[i];
    bits[n] = par; n++;
`endif
    bits[n] = 1'b1; n++;
  endfunction

  // Run one complete frame from capture to frame_done, checking every bit.
  task automatic run_frame(input string tag, input logic [1:0] port,
                           input logic [31:0] bits, input int n,
                           input logic rearm, input logic [3:0] raise,
                           input int stall_at);
    step();
    check({tag, ":gnt"},      32'(bus.gnt),      32'(4'b0001 << port));
    check({tag, ":busy0"},    32'(bus.busy),     32'd1);
    check({tag, ":start"},    32'(bus.ser_out),  32'(bits[0]));
    check({tag, ":cur_port"}, 32'(bus.cur_port), 32'(port));
    check({tag, ":st_start"}, 32'(bus.state_dbg), 32'd1);
    if (!rearm) begin
      req_v[port]  = 1'b0;
      len_v[port]  = 4'($urandom_range(0, 15));
      data_v[port] = 15'($urandom);
    end
    req_v = req_v | raise;
    drive();
    for (int k = 1; k < n; k++) begin
      step();
      check({tag, ":bit"},  32'(bus.ser_out),    32'(bits[k]));
      check({tag, ":gnt0"}, 32'(bus.gnt),        32'd0);
      check({tag, ":busy"}, 32'(bus.busy),       32'd1);
      check({tag, ":fd0"},  32'(bus.frame_done), 32'd0);
      if (k == stall_at) begin
        repeat (10) begin
          @(posedge clk);
          #1;
          check({tag, ":stall_bit"},   32'(bus.ser_out),   32'(bits[k]));
          check({tag, ":stall_state"}, 32'(bus.state_dbg), 32'd4);
        end
      end
    end
    step();
    check({tag, ":frame_done"}, 32'(bus.frame_done), 32'd1);
    check({tag, ":busy_end"},   32'(bus.busy),       32'd0);
    check({tag, ":idle_line"},  32'(bus.ser_out),    32'd1);
    check({tag, ":st_idle"},    32'(bus.state_dbg),  32'd0);
    @(posedge clk);
    #1;
    check({tag, ":fd_pulse"}, 32'(bus.frame_done), 32'd0);
  endtask

  logic [31:0] bits;
  int          n;

  initial begin
    req_v = '0;
    for (int i = 0; i < 4; i++) begin
      len_v[i]  = '0;
      data_v[i] = '0;
    end
    drive();

    // Reset, with a clk_en pulse and a pending request that must be ignored
    rst = 1'b0;
    req_v = 4'b0110;
    drive();
    step();
    step();
    check("rst:ser_out",    32'(bus.ser_out),    32'd1);
    check("rst:gnt",        32'(bus.gnt),        32'd0);
    check("rst:busy",       32'(bus.busy),       32'd0);
    check("rst:frame_done", 32'(bus.frame_done), 32'd0);
    check("rst:cur_port",   32'(bus.cur_port),   32'd0);
    check("rst:state",      32'(bus.state_dbg),  32'd0);
    req_v = '0;
    drive();
    @(negedge clk);
    rst = 1'b1;

    // No request: stays idle with the line high
    step();
    check("idle:ser_out", 32'(bus.ser_out),   32'd1);
    check("idle:state",   32'(bus.state_dbg), 32'd0);
    check("idle:gnt",     32'(bus.gnt),       32'd0);

    // Round robin with all four requesters re-arming: 0,1,2,3,0
    len_v[0] = 4'd2;  data_v[0] = 15'h0003;
    len_v[1] = 4'd1;  data_v[1] = 15'h0000;
    len_v[2] = 4'd5;  data_v[2] = 15'h0015;
    len_v[3] = 4'd0;  data_v[3] = 15'h7fff;
    req_v = 4'b1111;
    drive();
    for (int r = 0; r < 5; r++) begin
      build_frame(2'(r % 4), len_v[r % 4], data_v[r % 4], bits, n);
      run_frame("rr", 2'(r % 4), bits, n, 1'b1, 4'b0000, -1);
    end
    req_v = '0;
    drive();

    // Single frame on requester 1: len 3, data ...101 (pointer now 0)
    len_v[1] = 4'd3;
    data_v[1] = 15'b000000000000101;
    req_v = 4'b0010;
    drive();
`ifdef SER_PARITY_EN
    bits = 32'b111011100100; n = 12;
`else
    bits = 32'b11011100100;  n = 11;
`endif
    run_frame("single", 2'd1, bits, n, 1'b0, 4'b0000, -1);

    // Dropped request: requester 2 withdraws before any clk_en, 3 wins
    req_v = 4'b0100;
    drive();
    repeat (3) @(posedge clk);
    len_v[3] = 4'd0;
    req_v = 4'b1000;
    drive();
`ifdef SER_PARITY_EN
    bits = 32'b100000110;  n = 9;
`else
    bits = 32'b10000110;   n = 8;
`endif
    // Requester 0 raises during the frame; it must wait for IDLE
    run_frame("zero_len", 2'd3, bits, n, 1'b0, 4'b0001, -1);

    // Strobe gating: requester 0, len 4, data 0110, stall on a data bit
    len_v[0] = 4'd4;
    data_v[0] = 15'b000000000000110;
    drive();
    build_frame(2'd0, 4'd4, 15'b000000000000110, bits, n);
    run_frame("stall", 2'd0, bits, n, 1'b0, 4'b0000, 8);

    // Reset mid-frame on requester 1
    len_v[1] = 4'd3;
    data_v[1] = 15'b000000000000101;
    req_v = 4'b0010;
    drive();
    step();
    check("abort:gnt", 32'(bus.gnt), 32'd2);
    req_v = '0;
    drive();
    repeat (8) step();
    check("abort:in_data", 32'(bus.state_dbg), 32'd4);
    @(negedge clk);
    rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("abort:ser_out",    32'(bus.ser_out),    32'd1);
    check("abort:busy",       32'(bus.busy),       32'd0);
    check("abort:frame_done", 32'(bus.frame_done), 32'd0);
    check("abort:gnt0",       32'(bus.gnt),        32'd0);
    check("abort:state",      32'(bus.state_dbg),  32'd0);
    clk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort:no_fd", 32'(bus.frame_done), 32'd0);

    // After reset requester 0 has priority over 1
    len_v[0] = 4'd1;
    data_v[0] = 15'h0001;
    req_v = 4'b0011;
    drive();
    build_frame(2'd0, 4'd1, 15'h0001, bits, n);
    run_frame("post_rst", 2'd0, bits, n, 1'b0, 4'b0000, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
